// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate generator.
// Contents:
//   fmt_e     - decoded immediate format code
//   OPC_*     - RV opcode values that carry an immediate
//   payload_t - decoded result {imm, fmt, illegal}; imm is sized for the widest XLEN
//   sext64    - sign-extend a 32-bit value to 64 bits
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    localparam int unsigned MaxXlen = 64;

    typedef struct packed {
        logic [MaxXlen-1:0] imm;
        fmt_e               fmt;
        logic               illegal;
    } payload_t;

    function automatic logic [63:0] sext64(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe. Signal names are seen from the generator's side.
//   slave  : the generator (takes instr_i/valid_i/ready_i/flush_i, drives the rest)
//   master : the environment (upstream source plus downstream sink)
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [31:0]     instr_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] imm_o;
    fmt_e            fmt_o;
    logic            illegal_o;

    modport slave (
        input  flush_i, valid_i, instr_i, ready_i,
        output ready_o, valid_o, imm_o, fmt_o, illegal_o
    );

    modport master (
        output flush_i, valid_i, instr_i, ready_i,
        input  ready_o, valid_o, imm_o, fmt_o, illegal_o
    );
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode decode and immediate extraction.
// Ports:
//   instr - raw 32-bit instruction word
//   pl    - {imm sign/zero-extended to 64 bits, format, illegal}
// The 64-bit result truncated to 32 bits is the correct XLEN=32 immediate.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0] instr,
    output payload_t    pl
);
    localparam bit Rv64 = (XLEN == 64);

    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt32, shamt64;

    assign opc      = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    // Shift amounts are zero-extended; funct7/funct6 bits never reach the immediate.
    assign shamt32 = {27'b0, instr[24:20]};
    assign shamt64 = {26'b0, instr[25:20]};

    always_comb begin
        pl = '{imm: '0, fmt: FMT_NONE, illegal: 1'b1};
        case (opc)
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                pl = '{imm: sext64(imm_i), fmt: FMT_I, illegal: 1'b0};
            end
            OPC_OPIMM: begin
                if (is_shift) begin
                    pl = '{imm: sext64(Rv64 ? shamt64 : shamt32), fmt: FMT_I, illegal: 1'b0};
                end else begin
                    pl = '{imm: sext64(imm_i), fmt: FMT_I, illegal: 1'b0};
                end
            end
            OPC_OPIMM32: begin
                // Word-sized ops only exist on RV64; RV32 leaves the illegal default.
                if (Rv64) begin
                    pl = '{imm: sext64(is_shift ? shamt32 : imm_i), fmt: FMT_I, illegal: 1'b0};
                end
            end
            OPC_STORE:          pl = '{imm: sext64(imm_s), fmt: FMT_S, illegal: 1'b0};
            OPC_BRANCH:         pl = '{imm: sext64(imm_b), fmt: FMT_B, illegal: 1'b0};
            OPC_LUI, OPC_AUIPC: pl = '{imm: sext64(imm_u), fmt: FMT_U, illegal: 1'b0};
            OPC_JAL:            pl = '{imm: sext64(imm_j), fmt: FMT_J, illegal: 1'b0};
            default:            ;
        endcase
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one output register, optional skid entry, sync flush.
// Ports:
//   clk_i   - clock, rising edge
//   rst_n_i - asynchronous active-low reset
//   bus     - imm_gen_pipe_if.slave: flush_i, valid_i/ready_o/instr_i in,
//             valid_o/ready_i/imm_o/fmt_o/illegal_o out
// Parameters:
//   XLEN - 32 or 64
//   SKID - 1: skid entry, ready_o straight from a flop; 0: ready_o = !valid_o || ready_i
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SKID = 1
) (
    input logic            clk_i,
    input logic            rst_n_i,
    imm_gen_pipe_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    localparam entry_t EntryReset = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

    payload_t dec_pl;
    entry_t   dec_entry;
    entry_t   out_q, skid_q;
    logic     out_valid_q;
    logic     skid_free_q;
    logic     ready;
    logic     in_fire;
    logic     out_free;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr (bus.instr_i),
        .pl    (dec_pl)
    );

    assign dec_entry = '{imm: dec_pl.imm[XLEN-1:0], fmt: dec_pl.fmt, illegal: dec_pl.illegal};

    if (SKID != 0) begin : g_skid
        assign ready = skid_free_q;
    end else begin : g_noskid
        assign ready = !out_valid_q || bus.ready_i;
    end

    assign in_fire  = bus.valid_i && ready;
    // Output register can take new data this cycle (empty or draining).
    assign out_free = !out_valid_q || bus.ready_i;

    // With SKID=0, in_fire implies out_free, so the skid entry is never loaded.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            out_q       <= EntryReset;
            skid_free_q <= 1'b1;
            skid_q      <= EntryReset;
        end else if (bus.flush_i) begin
            out_valid_q <= 1'b0;
            skid_free_q <= 1'b1;
        end else if (out_free) begin
            if (!skid_free_q) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
                skid_free_q <= 1'b1;
            end else if (in_fire) begin
                out_q       <= dec_entry;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q      <= dec_entry;
            skid_free_q <= 1'b0;
        end
    end

    assign bus.ready_o   = ready;
    assign bus.valid_o   = out_valid_q;
    assign bus.imm_o     = out_q.imm;
    assign bus.fmt_o     = out_q.fmt;
    assign bus.illegal_o = out_q.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic        ready_dn;
    logic [31:0] instr;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64)) if64 ();
    imm_gen_pipe_if #(.XLEN(32)) if0 ();

    assign if32.flush_i = flush;
    assign if32.valid_i = valid;
    assign if32.instr_i = instr;
    assign if32.ready_i = ready_dn;
    assign if64.flush_i = flush;
    assign if64.valid_i = valid;
    assign if64.instr_i = instr;
    assign if64.ready_i = ready_dn;
    assign if0.flush_i  = flush;
    assign if0.valid_i  = valid;
    assign if0.instr_i  = instr;
    assign if0.ready_i  = ready_dn;

    imm_gen_pipe #(.XLEN(32), .SKID(1)) u_dut32 (.clk_i(clk), .rst_n_i(rst_n), .bus(if32));
    imm_gen_pipe #(.XLEN(64), .SKID(1)) u_dut64 (.clk_i(clk), .rst_n_i(rst_n), .bus(if64));
    imm_gen_pipe #(.XLEN(32), .SKID(0)) u_dut0  (.clk_i(clk), .rst_n_i(rst_n), .bus(if0));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        int          xlen;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [63:0] imm,
                           input logic [2:0] fmt, input logic ill, input exp_t e);
        chk({tag, " valid"},   64'(v),   64'd1);
        chk({tag, " imm"},     imm,      e.imm);
        chk({tag, " fmt"},     64'(fmt), 64'(e.fmt));
        chk({tag, " illegal"}, 64'(ill), 64'(e.illegal));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: immediates assembled as signed integers from the bit-field weights.
    function automatic exp_t model(input logic [31:0] w, input int xlen);
        exp_t   r;
        longint v;
        bit     ok;
        logic [63:0] u;
        logic [2:0]  f3;
        f3 = w[14:12];
        ok = 1'b1;
        v  = 0;
        r.fmt = 3'd7;
        case (w[6:0])
            7'h03, 7'h67, 7'h73: begin
                v = longint'(w[31:20]);
                if (v >= 2048) v -= 4096;
                r.fmt = 3'd0;
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
                end else begin
                    v = longint'(w[31:20]);
                    if (v >= 2048) v -= 4096;
                end
                r.fmt = 3'd0;
            end
            7'h1B: begin
                if (xlen != 64) ok = 1'b0;
                else if (f3 == 3'd1 || f3 == 3'd5) v = longint'(w[24:20]);
                else begin
                    v = longint'(w[31:20]);
                    if (v >= 2048) v -= 4096;
                end
                r.fmt = ok ? 3'd0 : 3'd7;
            end
            7'h23: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (v >= 2048) v -= 4096;
                r.fmt = 3'd1;
            end
            7'h63: begin
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (w[31]) v -= 8192;
                r.fmt = 3'd2;
            end
            7'h37, 7'h17: begin
                v = longint'(w[31:12]) * 4096;
                if (w[31]) v -= (longint'(1) << 32);
                r.fmt = 3'd3;
            end
            7'h6F: begin
                v = longint'(w[31]) * (longint'(1) << 20) + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (w[31]) v -= (longint'(1) << 21);
                r.fmt = 3'd4;
            end
            default: ok = 1'b0;
        endcase
        u = v;
        if (!ok) u = 64'd0;
        r.imm     = (xlen == 64) ? u : {32'd0, u[31:0]};
        r.illegal = !ok;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [12];
        logic [31:0] w;
        opcs = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                 7'h17, 7'h67, 7'h73, 7'h6F, 7'h33, 7'h7F};
        w      = $urandom;
        w[6:0] = opcs[$urandom_range(0, 11)];
        return w;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] w);
        chk_out(tag, if32.valid_o, {32'd0, if32.imm_o}, if32.fmt_o, if32.illegal_o,
                model(w, 32));
    endtask

    task automatic chk64(input string tag, input logic [31:0] w);
        chk_out(tag, if64.valid_o, if64.imm_o, if64.fmt_o, if64.illegal_o, model(w, 64));
    endtask

    task automatic chk0(input string tag, input logic [31:0] w);
        chk_out(tag, if0.valid_o, {32'd0, if0.imm_o}, if0.fmt_o, if0.illegal_o, model(w, 32));
    endtask

    initial begin
        logic [31:0] a, b, c, w;
        exp_t        e;

        vecs[0]  = '{32'hFFF00093, 32, 64'h00000000FFFFFFFF, 3'd0, 1'b0};
        vecs[1]  = '{32'hFE112E23, 32, 64'h00000000FFFFFFFC, 3'd1, 1'b0};
        vecs[2]  = '{32'hFE000CE3, 32, 64'h00000000FFFFFFF8, 3'd2, 1'b0};
        vecs[3]  = '{32'h123450B7, 32, 64'h0000000012345000, 3'd3, 1'b0};
        vecs[4]  = '{32'h0010006F, 32, 64'h0000000000000800, 3'd4, 1'b0};
        vecs[5]  = '{32'h4030D093, 32, 64'h0000000000000003, 3'd0, 1'b0};
        vecs[6]  = '{32'h01F09093, 32, 64'h000000000000001F, 3'd0, 1'b0};
        vecs[7]  = '{32'h0000001B, 32, 64'h0000000000000000, 3'd7, 1'b1};
        vecs[8]  = '{32'h00000033, 32, 64'h0000000000000000, 3'd7, 1'b1};
        vecs[9]  = '{32'h80000037, 64, 64'hFFFFFFFF80000000, 3'd3, 1'b0};
        vecs[10] = '{32'h03F09093, 64, 64'h000000000000003F, 3'd0, 1'b0};
        vecs[11] = '{32'h0000001B, 64, 64'h0000000000000000, 3'd0, 1'b0};
        vecs[12] = '{32'hFFF00093, 64, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
        vecs[13] = '{32'hFE000CE3, 64, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};
        vecs[14] = '{32'h4030D09B, 64, 64'h0000000000000003, 3'd0, 1'b0};
        vecs[15] = '{32'hFFF0009B, 64, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};

        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready_dn = 1'b1; instr = 32'd0;
        step();
        step();
        chk("rst valid32",   64'(if32.valid_o),   64'd0);
        chk("rst imm32",     64'(if32.imm_o),     64'd0);
        chk("rst fmt32",     64'(if32.fmt_o),     64'd7);
        chk("rst illegal32", 64'(if32.illegal_o), 64'd0);
        chk("rst ready32",   64'(if32.ready_o),   64'd1);
        chk("rst imm64",     if64.imm_o,          64'd0);
        chk("rst ready0",    64'(if0.ready_o),    64'd1);
        rst_n = 1'b1;
        step();

        // Back-to-back table vectors, each checked one cycle after acceptance.
        for (int i = 0; i < 16; i++) begin
            valid = 1'b1;
            instr = vecs[i].instr;
            step();
            e = '{vecs[i].imm, vecs[i].fmt, vecs[i].illegal};
            if (vecs[i].xlen == 32) begin
                chk_out($sformatf("vec%0d x32", i), if32.valid_o, {32'd0, if32.imm_o},
                        if32.fmt_o, if32.illegal_o, e);
                chk_out($sformatf("vec%0d skid0", i), if0.valid_o, {32'd0, if0.imm_o},
                        if0.fmt_o, if0.illegal_o, e);
            end else begin
                chk_out($sformatf("vec%0d x64", i), if64.valid_o, if64.imm_o,
                        if64.fmt_o, if64.illegal_o, e);
            end
        end
        valid = 1'b0;
        step();
        chk("idle valid32", 64'(if32.valid_o), 64'd0);

        // Skid: A, B accepted under stall, C held off, then drained in order.
        a = 32'hFFF00093; b = 32'h123450B7; c = 32'h0010006F;
        ready_dn = 1'b0;
        valid = 1'b1; instr = a;
        #1;
        chk("skid ready before A", 64'(if32.ready_o), 64'd1);
        step();
        chk32("skid A x32", a);
        chk64("skid A x64", a);
        chk("skid ready after A", 64'(if32.ready_o), 64'd1);
        chk("noskid ready stalled", 64'(if0.ready_o), 64'd0);
        instr = b;
        step();
        chk("skid ready after B", 64'(if32.ready_o), 64'd0);
        chk32("skid A hold1", a);
        instr = c;
        step();
        chk("skid ready C held", 64'(if32.ready_o), 64'd0);
        chk32("skid A hold2", a);
        chk64("skid A hold x64", a);
        ready_dn = 1'b1;
        #1;
        chk("noskid ready drain", 64'(if0.ready_o), 64'd1);
        step();
        chk32("skid B x32", b);
        chk64("skid B x64", b);
        chk("skid ready reopened", 64'(if32.ready_o), 64'd1);
        step();
        chk32("skid C x32", c);
        chk64("skid C x64", c);
        valid = 1'b0;
        step();
        chk("skid drained", 64'(if32.valid_o), 64'd0);
        step();

        // Streaming: one transfer per cycle, every output against the model.
        ready_dn = 1'b1;
        for (int k = 0; k < 100; k++) begin
            w = rand_instr();
            valid = 1'b1;
            instr = w;
            step();
            chk32($sformatf("stream%0d x32", k), w);
            chk64($sformatf("stream%0d x64", k), w);
            chk0($sformatf("stream%0d skid0", k), w);
            chk($sformatf("stream%0d ready32", k), 64'(if32.ready_o), 64'd1);
        end
        valid = 1'b0;
        step();

        // Flush with two and then one entry held, new input offered in the flush cycle.
        for (int held = 2; held >= 1; held--) begin
            ready_dn = 1'b0;
            valid = 1'b1;
            for (int j = 0; j < held; j++) begin
                instr = rand_instr();
                step();
            end
            flush = 1'b1;
            instr = 32'hFE112E23;
            step();
            flush = 1'b0;
            valid = 1'b0;
            chk($sformatf("flush%0d valid32", held), 64'(if32.valid_o), 64'd0);
            chk($sformatf("flush%0d ready32", held), 64'(if32.ready_o), 64'd1);
            chk($sformatf("flush%0d valid64", held), 64'(if64.valid_o), 64'd0);
            chk($sformatf("flush%0d valid0", held),  64'(if0.valid_o),  64'd0);
            ready_dn = 1'b1;
            step();
            chk($sformatf("flush%0d no out32", held), 64'(if32.valid_o), 64'd0);
            chk($sformatf("flush%0d no out64", held), 64'(if64.valid_o), 64'd0);
            step();
            chk($sformatf("flush%0d still empty", held), 64'(if32.valid_o), 64'd0);
        end

        // Reset in the middle of a stall clears state without a clock edge.
        ready_dn = 1'b0;
        valid = 1'b1;
        instr = 32'h4030D093;
        step();
        instr = 32'h01F09093;
        step();
        valid = 1'b0;
        chk("pre-reset held32", 64'(if32.valid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid32", 64'(if32.valid_o), 64'd0);
        chk("async rst ready32", 64'(if32.ready_o), 64'd1);
        chk("async rst valid64", 64'(if64.valid_o), 64'd0);
        chk("async rst valid0",  64'(if0.valid_o),  64'd0);
        step();
        rst_n = 1'b1;
        ready_dn = 1'b1;
        step();
        chk("post-reset valid32", 64'(if32.valid_o), 64'd0);
        chk("post-reset fmt32",   64'(if32.fmt_o),   64'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It takes a raw 32-bit instruction word and finds the immediate format from the opcode; no external select is needed. It produces the sign- or zero-extended immediate at XLEN width, the decoded format and an illegal flag. One registered stage with valid/ready handshake, an optional skid entry for full throughput under backpressure, and a synchronous flush.

Parameters:
XLEN, 32, output datapath width; legal values 32 or 64.
SKID, 1, 1 = output register plus skid register (ready_o is registered); 0 = single output register, with ready_o = !valid_o || ready_i.

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
flush_i  input  1  synchronous flush of all held entries
valid_i  input  1  instr_i is valid
ready_o  output  1  block can accept instr_i
instr_i  input  32  raw RV instruction
valid_o  output  1  outputs are valid
ready_i  input  1  downstream accepts the outputs
imm_o  output  XLEN  extended immediate
fmt_o  output  3  decoded format code
illegal_o  output  1  opcode is not immediate-bearing or not legal for this XLEN

Behaviour:
- Reset (async assert, sync release): valid_o=0, imm_o=0, fmt_o=FMT_NONE, illegal_o=0, skid empty, ready_o=1.
- Opcode decode (instr_i[6:0]):
  - I format: 0000011, 0010011, 1100111, 1110011, plus 0011011 when XLEN=64.
  - S format: 0100011.
  - B format: 1100011.
  - U format: 0110111, 0010111.
  - J format: 1101111.
  - Any other opcode, or 0011011 when XLEN=32: fmt=FMT_NONE, imm=0, illegal=1.
- Extension rules:
  - I: sign-extend instr[31:20].
  - S: sign-extend {instr[31:25], instr[11:7]}.
  - B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Shift exception: opcode 0010011 or 0011011 with funct3 001 or 101 gives fmt=FMT_I and imm = zero-extended shamt.
  - shamt is instr[24:20] when XLEN=32 or for 0011011.
  - shamt is instr[25:20] for 0010011 when XLEN=64.
  - funct7/funct6 bits are excluded from imm.
- Latency: exactly 1 cycle from an accepted input to valid_o when the output is free.
- Transfer rules: input transfers on valid_i && ready_o; output transfers on valid_o && ready_i.
- While valid_o && !ready_i, imm_o, fmt_o and illegal_o hold stable.
- SKID=1:
  - ready_o = !skid_valid, registered.
  - An input accepted while the output is stalled goes into the skid entry, and ready_o drops the next cycle.
  - When the output drains, the skid entry moves to the output. Order is preserved.
  - Sustained valid_i with ready_i=1 gives 1 transfer per cycle.
- SKID=0: a simultaneous output drain and input accept in the same cycle is allowed, so throughput is 1 per cycle.
- flush_i (priority over everything): next cycle valid_o=0, skid empty, ready_o=1. An input presented in the flush cycle is dropped. imm_o and fmt_o are don't-care while valid_o=0.
- Reset mid-stall: all held entries are discarded immediately.
- Illegal instructions still flow through the pipe, with illegal_o=1.

Decomposition:
- Package imm_pkg holds:
  - fmt_e: FMT_I=0, FMT_S=1, FMT_B=2, FMT_U=3, FMT_J=4, FMT_NONE=7.
  - Opcode constants: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL.
  - A payload struct {imm, fmt, illegal}.
- One combinational sub-module, imm_decode, maps (instr, XLEN) to the payload. The top holds the handshake, skid and flush logic.

Test Plan:
- XLEN=32: 0xFFF00093 (addi -1) -> imm_o=0xFFFFFFFF, fmt_o=0. 0xFE112E23 (sw -4) -> 0xFFFFFFFC, fmt 1. 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt 2. All with 1-cycle latency.
- XLEN=32: 0x123450B7 (lui) -> 0x12345000, fmt 3. 0x0010006F (jal +2048) -> 0x00000800, fmt 4. 0x4030D093 (srai 3) -> 0x00000003. 0x01F09093 (slli 31) -> 0x0000001F.
- XLEN=64: 0x80000037 -> 0xFFFFFFFF80000000. 0x03F09093 (slli 63) -> 0x3F. 0x0000001B (addiw, opcode 0011011) accepted with illegal_o=0. The same word at XLEN=32 -> illegal_o=1, fmt 7, imm 0.
- SKID=1, ready_i=0, three back-to-back inputs A, B, C:
  - A and B are accepted and ready_o drops; C is held by the source.
  - Raise ready_i: A, B, C come out on consecutive cycles, in order and unchanged.
- Streaming: 100 random instructions with ready_i=1 -> 100 outputs in 100 consecutive cycles, each matching the reference model.
- Stall with 2 entries held, then pulse flush_i together with valid_i=1 -> next cycle valid_o=0 and ready_o=1, no output for the flushed inputs. Then assert rst_n_i=0 mid-stream -> valid_o=0 immediately, without waiting for a clock edge.
